// File: rtl/adder_switch_ctrl.sv
// Sequencer for a row of adder switches: buffers per-step configs in a small FIFO
// and issues one step per cycle during a run, then drains the adder pipeline.
module adder_switch_ctrl #(
    parameter int NUM_AS  = 8,
    parameter int SEL_IN  = 2,
    parameter int DEPTH   = 4,
    parameter int STEP_W  = 8,
    parameter int ADD_LAT = 1,
    localparam int CFG_W   = 4 + SEL_IN,
    localparam int ENTRY_W = NUM_AS * CFG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_cfg_valid,
    output logic                     o_cfg_ready,
    input  logic [ENTRY_W-1:0]       i_cfg_data,
    input  logic                     i_start,
    input  logic [STEP_W-1:0]        i_num_steps,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [NUM_AS-1:0]        o_as_valid,
    output logic [NUM_AS-1:0]        o_as_add_en,
    output logic [3*NUM_AS-1:0]      o_as_cmd,
    output logic [SEL_IN*NUM_AS-1:0] o_as_sel,
    output logic                     o_out_valid,
    output logic [15:0]              o_stall_cnt
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int DRN_W = $clog2(ADD_LAT + 2);
    localparam int SR_W  = ADD_LAT + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state_q, state_d;

    logic [ENTRY_W-1:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ready_q;
    logic [STEP_W-1:0]        rem_q, rem_d;
    logic [DRN_W-1:0]         drn_q, drn_d;
    logic [15:0]              stall_q, stall_d;
    logic                     asv_q;
    logic [NUM_AS-1:0]        add_en_q, add_en_d;
    logic [3*NUM_AS-1:0]      cmd_q, cmd_d;
    logic [SEL_IN*NUM_AS-1:0] sel_q, sel_d;
    logic [SR_W-1:0]          ov_sr_q;
    logic                     push, pop;
    logic [ENTRY_W-1:0]       head;

    // Ready comes from the registered count, so a full FIFO refuses a push even
    // when a pop happens in the same cycle.
    assign push = i_cfg_valid && ready_q;
    assign head = mem_q[rd_ptr_q];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        drn_d   = drn_q;
        stall_d = stall_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    rem_d   = i_num_steps;
                    stall_d = '0;
                    state_d = (i_num_steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt_q != '0) begin
                    pop   = 1'b1;
                    rem_d = rem_q - STEP_W'(1);
                    if (rem_q == STEP_W'(1)) begin
                        state_d = DRAIN;
                        drn_d   = DRN_W'(ADD_LAT + 1);
                    end
                end else if (stall_q != 16'hFFFF) begin
                    stall_d = stall_q + 16'd1;
                end
            end
            // First DRAIN cycle is the final issue; the count covers the cycles after it.
            DRAIN: begin
                if (drn_q == '0) state_d = DONE;
                else             drn_d   = drn_q - DRN_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
    end

    always_comb begin
        add_en_d = add_en_q;
        cmd_d    = cmd_q;
        sel_d    = sel_q;
        if (pop) begin
            for (int k = 0; k < NUM_AS; k++) begin
                add_en_d[k]               = head[k*CFG_W + CFG_W - 1];
                cmd_d[k*3 +: 3]           = head[k*CFG_W + SEL_IN +: 3];
                sel_d[k*SEL_IN +: SEL_IN] = head[k*CFG_W +: SEL_IN];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= i_cfg_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            rem_q    <= '0;
            drn_q    <= '0;
            stall_q  <= '0;
            asv_q    <= 1'b0;
            add_en_q <= '0;
            cmd_q    <= '0;
            sel_q    <= '0;
            ov_sr_q  <= '0;
        end else begin
            state_q  <= state_d;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q    <= cnt_d;
            ready_q  <= (cnt_d != CNT_W'(DEPTH));
            rem_q    <= rem_d;
            drn_q    <= drn_d;
            stall_q  <= stall_d;
            asv_q    <= pop;
            add_en_q <= add_en_d;
            cmd_q    <= cmd_d;
            sel_q    <= sel_d;
            ov_sr_q  <= (ov_sr_q << 1) | SR_W'(asv_q);
        end
    end

    assign o_cfg_ready = ready_q;
    assign o_busy      = (state_q != IDLE);
    assign o_done      = (state_q == DONE);
    assign o_as_valid  = {NUM_AS{asv_q}};
    assign o_as_add_en = add_en_q;
    assign o_as_cmd    = cmd_q;
    assign o_as_sel    = sel_q;
    assign o_out_valid = ov_sr_q[ADD_LAT];
    assign o_stall_cnt = stall_q;
endmodule

// File: doc/adder_switch_ctrl.md
ADDER_SWITCH_CTRL -- requirements
Module: adder_switch_ctrl

Interface
REQ-001 Parameter NUM_AS, default 8: number of adder switches sequenced.
REQ-002 Parameter SEL_IN, default 2: reduction-mux select width per switch.
REQ-003 Parameter DEPTH, default 4, power of two: config FIFO entries.
REQ-004 Parameter STEP_W, default 8: step-count width.
REQ-005 Parameter ADD_LAT, default 1: adder pipeline cycles after the switch register stage.
REQ-006 Derived: CFG_W = 4+SEL_IN bits per switch, laid out as {add_en, cmd[2:0], sel}; ENTRY_W = NUM_AS*CFG_W; switch k occupies bits [k*CFG_W +: CFG_W].
REQ-007 clk  in  1  the block's only clock, rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 i_cfg_valid  in  1  config entry offered.
REQ-010 o_cfg_ready  out  1  FIFO can accept an entry.
REQ-011 i_cfg_data  in  ENTRY_W  one step's configuration for all switches.
REQ-012 i_start  in  1  start-run pulse.
REQ-013 i_num_steps  in  STEP_W  steps in the run, sampled with i_start.
REQ-014 o_busy  out  1  run in progress.
REQ-015 o_done  out  1  one-cycle run-complete pulse.
REQ-016 o_as_valid  out  NUM_AS  per-switch i_valid.
REQ-017 o_as_add_en  out  NUM_AS  per-switch i_add_en.
REQ-018 o_as_cmd  out  3*NUM_AS  per-switch i_cmd.
REQ-019 o_as_sel  out  SEL_IN*NUM_AS  per-switch i_sel.
REQ-020 o_out_valid  out  1  high when switch outputs for an issued step are valid.
REQ-021 o_stall_cnt  out  16  cycles spent in RUN with the FIFO empty, saturating.

Function
REQ-022 A config push SHALL occur when i_cfg_valid && o_cfg_ready; o_cfg_ready = !full, registered count-based.
REQ-023 A push into a full FIFO SHALL NOT occur, even if a pop happens in the same cycle.
REQ-024 Pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH and remain unchanged on a simultaneous push and pop.
REQ-025 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-026 IDLE: i_start SHALL latch i_num_steps into a remaining-step counter and clear o_stall_cnt; the next state is RUN, or DONE if i_num_steps==0.
REQ-027 i_start SHALL be ignored outside IDLE.
REQ-028 RUN with FIFO non-empty: pop one entry and decrement remaining.
REQ-029 The popped fields SHALL be registered onto o_as_add_en, o_as_cmd and o_as_sel, with o_as_valid = all ones, the following cycle (issue latency 1).
REQ-030 RUN with FIFO empty: no pop; o_as_valid = 0 next cycle; o_as_cmd/sel/add_en hold their last values; o_stall_cnt increments, saturating at 16'hFFFF.
REQ-031 No bypass: an entry pushed in cycle t SHALL be poppable no earlier than cycle t+1.
REQ-032 When the last step is popped (remaining 1 -> 0), the FSM SHALL go to DRAIN.
REQ-033 DRAIN SHALL last ADD_LAT+1 cycles, counted after the final issue cycle, then go to DONE.
REQ-034 DONE SHALL last 1 cycle: o_done=1, then return to IDLE.
REQ-035 o_busy = 1 in RUN, DRAIN and DONE.
REQ-036 o_out_valid SHALL equal |o_as_valid delayed by ADD_LAT+1 cycles through a shift register.
REQ-037 The o_out_valid shift register SHALL be cleared only by rst, so the final step's o_out_valid fires before o_done.
REQ-038 Outside RUN issue cycles, o_as_valid SHALL be 0.
REQ-039 Pushes SHALL be accepted in every state, so the next run can be preloaded.

Reset
REQ-040 On rst=1 at a clock edge: FSM=IDLE; FIFO pointers and count = 0; o_cfg_ready=1; o_busy=0; o_done=0; o_as_valid=0; o_as_add_en=0; o_as_cmd=0; o_as_sel=0; o_out_valid=0 and its shift register cleared; o_stall_cnt=0.
REQ-041 Reset mid-run SHALL abort the run with no o_done and discard FIFO contents.

Verification
REQ-042 Push 3 entries, then i_start with i_num_steps=3 -> o_as_valid=8'hFF for 3 consecutive cycles carrying the entries in push order; with ADD_LAT=1, o_out_valid high 2 cycles after each issue; o_done exactly 1 cycle after DRAIN's 2 cycles.
REQ-043 Push DEPTH=4 entries -> o_cfg_ready=0; hold i_cfg_valid -> 5th entry not accepted; one pop -> ready=1 the next cycle.
REQ-044 i_start with i_num_steps=2 and an empty FIFO for 5 cycles, then push 2 entries -> o_stall_cnt=5; 2 issues follow; o_done asserted.
REQ-045 i_start with i_num_steps=0 -> o_busy=1 for 1 cycle with o_done=1 then; no o_as_valid.
REQ-046 rst asserted during RUN after 1 of 4 steps -> next cycle all outputs at reset values; no o_done; o_cfg_ready=1.
REQ-047 i_start pulsed during RUN -> ignored; step count and completion unchanged.
